mem_access_sequencer: RTL
=========================

// Module: mem_access_sequencer
// PURPOSE
//  Transaction sequencer directly upstream of the memory-enable decoder.
//  - Accepts a burst request: block, direction, start address, length.
//  - Drives the 2-bit memoryena code {block, write}: 00 rd blk1, 01 wr blk1, 10 rd blk2, 11 wr blk2.
//  - Drives mem_strobe, mem_addr and per-beat handshakes with the deserializer (write path) and serializer (read path).
// PARAMETERS
//  ADDR_W  10  memory word-address width
//  LEN_W   8   burst length field width (req_len = beats-1)
//  RD_LAT  1   BRAM read latency in cycles, >=1
// PORTS
//  clk           in   1       system clock, all logic rising-edge
//  rst           in   1       asynchronous, active-high reset
//  req_valid     in   1       request offered
//  req_ready     out  1       sequencer idle, request accepted when valid&ready
//  req_write     in   1       1=write burst, 0=read burst
//  req_block     in   1       0=block1, 1=block2
//  req_addr      in   ADDR_W  start word address
//  req_len       in   LEN_W   beats minus one (0 -> 1 beat)
//  memoryena     out  2       {block, write} code to decoder, stable for whole burst
//  mem_strobe    out  1       memory access issued this cycle
//  mem_addr      out  ADDR_W  word address of current beat
//  deseri_valid  in   1       deserializer holds a complete word
//  deseri_ack    out  1       word consumed this cycle
//  seri_busy     in   1       serializer still shifting previous word
//  seri_load     out  1       BRAM output valid, serializer loads it this cycle
//  busy          out  1       burst in progress (not IDLE)
//  done          out  1       one-cycle pulse, burst complete
// BEHAVIOUR
//  - Reset: state IDLE; memoryena=2'b00, mem_addr=0, beat count=0.
//    - mem_strobe, deseri_ack, seri_load, busy, done = 0; req_ready=1 after reset release.
//  - Reset mid-burst: burst is abandoned, no done pulse, no further strobes.
//  - States: IDLE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_LOAD.
//  - IDLE: req_ready=1. On req_valid, latch memoryena={req_block,req_write}, mem_addr=req_addr, cnt=req_len.
//    - Next state: WR_WAIT if write, else RD_ISSUE.
//  - WR_WAIT: mem_strobe = deseri_ack = deseri_valid (combinational, same cycle).
//    - On strobe: mem_addr+1, cnt-1.
//    - Strobe with cnt==0 -> IDLE with done=1 next cycle.
//  - RD_ISSUE: when !seri_busy, mem_strobe=1 -> RD_WAIT. When seri_busy, hold with no strobe.
//  - RD_WAIT: wait RD_LAT-1 further cycles (0 when RD_LAT=1) -> RD_LOAD.
//  - RD_LOAD: seri_load=1 for exactly one cycle; mem_addr+1, cnt-1.
//    - cnt==0 -> IDLE with done=1 next cycle, else -> RD_ISSUE.
//  - Read beat period: >= RD_LAT+2 cycles; each beat waits for serializer free.
//  - Address arithmetic: modulo 2**ADDR_W; wraps max->0 inside a burst silently.
//  - done and req_ready are both high in the completion cycle.
//    - A request accepted then starts the next burst (back-to-back, 1 IDLE cycle).
//  - Input sampling: req_* ignored outside IDLE; deseri_valid ignored outside WR_WAIT; seri_busy ignored outside RD_ISSUE.
//  - mem_strobe never asserted in IDLE.
//  - memoryena changes only on request acceptance or reset.
//  - busy = (state != IDLE); registered outputs except mem_strobe and deseri_ack in WR_WAIT.
// STRUCTURE
//  - Package mem_seq_pkg:
//    - seq_state_t enum.
//    - MEMENA_RD_B1/WR_B1/RD_B2/WR_B2 constants (2'b00/01/10/11).
//  - Sub-module mem_seq_addr_gen: loadable address register + down-counter with last flag.
//  - FSM and handshake logic stay in the top module.
// TESTING
//  - Reset: assert rst mid read burst addr 0x010 len 3.
//    -> all outputs 0 at once, no done; after release req_ready=1, memoryena=00.
//  - Write blk2, addr 0x020, len 3, deseri_valid pulsed on 4 spaced cycles.
//    -> memoryena=11, 4 strobes at 0x020..0x023 coincident with deseri_ack, done 1 cycle after last.
//  - Read blk1, addr 0x3FE, len 3, RD_LAT=1, seri_busy=0.
//    -> strobes at 0x3FE,0x3FF,0x000,0x001 (wrap), seri_load 1 cycle after each, single done.
//  - Read with seri_busy held high 5 cycles after first load.
//    -> no second strobe until busy drops, then strobe next cycle, addresses contiguous.
//  - Back-to-back: req_valid held through done, second req read blk2.
//    -> accepted in done cycle, memoryena switches 01->10 only then.
//  - RD_LAT=3, 1-beat read -> seri_load exactly 3 cycles after strobe; req_len=0 gives exactly one beat.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and memory-enable codes for the memory access sequencer.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrWait,
        StRdIssue,
        StRdWait,
        StRdLoad
    } seq_state_t;

    localparam logic [1:0] MEMENA_RD_B1 = 2'b00;
    localparam logic [1:0] MEMENA_WR_B1 = 2'b01;
    localparam logic [1:0] MEMENA_RD_B2 = 2'b10;
    localparam logic [1:0] MEMENA_WR_B2 = 2'b11;

    // Decoder code is {block, write}.
    function automatic logic [1:0] memena_code(input logic blk, input logic wr);
        return {blk, wr};
    endfunction

endpackage

// File: rtl/mem_seq_addr_gen.sv
// Burst address register plus remaining-beat down-counter with last-beat flag.
module mem_seq_addr_gen #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;

    // Address wraps modulo 2**ADDR_W by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            addr_q <= load_addr;
            cnt_q  <= load_len;
        end else if (step) begin
            addr_q <= addr_q + ADDR_ONE;
            cnt_q  <= cnt_q - CNT_ONE;
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Burst sequencer driving the memory-enable decoder, BRAM strobe/address and the
// per-beat handshakes with the write deserializer and read serializer.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_block,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic [1:0]        memoryena,
    output logic              mem_strobe,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              deseri_valid,
    output logic              deseri_ack,
    input  logic              seri_busy,
    output logic              seri_load,
    output logic              busy,
    output logic              done
);

    localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    seq_state_t        state_q;
    logic [1:0]        memoryena_q;
    logic              rd_strobe_q;
    logic              seri_load_q;
    logic              busy_q;
    logic              done_q;
    logic              req_ready_q;
    logic [WAIT_W-1:0] wait_q;

    logic              accept;
    logic              wr_beat;
    logic              step;
    logic              last;

    assign accept  = (state_q == StIdle) && req_ready_q && req_valid;
    assign wr_beat = (state_q == StWrWait) && deseri_valid;
    assign step    = wr_beat || (state_q == StRdLoad);

    mem_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_addr (req_addr),
        .load_len  (req_len),
        .step      (step),
        .addr      (mem_addr),
        .last      (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            memoryena_q <= MEMENA_RD_B1;
            rd_strobe_q <= 1'b0;
            seri_load_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            rd_strobe_q <= 1'b0;
            seri_load_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        memoryena_q <= memena_code(req_block, req_write);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= req_write ? StWrWait : StRdIssue;
                    end
                end
                StWrWait: begin
                    if (deseri_valid && last) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StRdIssue: begin
                    if (!seri_busy) begin
                        rd_strobe_q <= 1'b1;
                        wait_q      <= WAIT_W'(RD_LAT - 1);
                        state_q     <= StRdWait;
                    end
                end
                StRdWait: begin
                    // Strobe cycle counts as the first of RD_LAT wait cycles.
                    if (wait_q == '0) begin
                        seri_load_q <= 1'b1;
                        state_q     <= StRdLoad;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                StRdLoad: begin
                    if (last) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        state_q <= StRdIssue;
                    end
                end
                default: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Write beats strobe combinationally so the deserializer word is consumed same cycle.
    assign mem_strobe = (state_q == StWrWait) ? deseri_valid : rd_strobe_q;
    assign deseri_ack = wr_beat;
    assign memoryena  = memoryena_q;
    assign seri_load  = seri_load_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign req_ready  = req_ready_q;

endmodule
